// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, state encoding and counter sizing
package uart_pkg;

   localparam int DBIT_DEF    = 8;
   localparam int SB_TICK_DEF = 16;
   localparam int OVERSAMPLE  = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } state_t;

   // Tick counter must reach both OVERSAMPLE-1 and SB_TICK-1 (1.5/2 stop bits)
   function automatic int cnt_width(input int sb_tick);
      return $clog2((sb_tick > OVERSAMPLE) ? sb_tick : OVERSAMPLE);
   endfunction

endpackage

// File: rtl/uart_fifo_tx_if.sv
// rtl/uart_fifo_tx_if.sv - FWFT FIFO read port between the FIFO and the UART transmitter
interface uart_fifo_tx_if
   import uart_pkg::*;
#(
   parameter int DBIT = DBIT_DEF
) ();
   logic            fifo_empty;
   logic [DBIT-1:0] fifo_r_data;
   logic            fifo_rd;

   modport master (
      input  fifo_empty,
      input  fifo_r_data,
      output fifo_rd
   );

   modport slave (
      output fifo_empty,
      output fifo_r_data,
      input  fifo_rd
   );
endinterface

// File: rtl/uart_fifo_tx.sv
// rtl/uart_fifo_tx.sv - 8N1 UART transmitter draining a first-word-fall-through byte FIFO
module uart_fifo_tx
   import uart_pkg::*;
#(
   parameter int DBIT    = DBIT_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_tick,
   uart_fifo_tx_if.master   fifo,
   output logic             tx,
   output logic             tx_busy
);

   localparam int SCW = cnt_width(SB_TICK);
   localparam int NCW = (DBIT > 1) ? $clog2(DBIT) : 1;

   localparam logic [SCW-1:0] S_LAST    = SCW'(OVERSAMPLE - 1);
   localparam logic [SCW-1:0] STOP_LAST = SCW'(SB_TICK - 1);
   localparam logic [NCW-1:0] N_LAST    = NCW'(DBIT - 1);

   state_t            r_state;
   logic [SCW-1:0]    r_s_cnt;
   logic [NCW-1:0]    r_n_cnt;
   logic [DBIT-1:0]   r_b_reg;
   logic              r_tx;
   logic [DBIT-1:0]   w_b_shift;
   logic              w_pop;

   assign w_b_shift = r_b_reg >> 1;
   // Pop is gated by reset so a held reset never drains the FIFO
   assign w_pop     = !reset && (r_state == IDLE) && !fifo.fifo_empty;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_s_cnt <= '0;
         r_n_cnt <= '0;
         r_b_reg <= '0;
         r_tx    <= 1'b1;
      end else begin
         case (r_state)
            IDLE: begin
               r_tx <= 1'b1;
               if (!fifo.fifo_empty) begin
                  r_b_reg <= fifo.fifo_r_data;
                  r_s_cnt <= '0;
                  r_state <= START;
                  r_tx    <= 1'b0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (r_s_cnt == S_LAST) begin
                     r_s_cnt <= '0;
                     r_n_cnt <= '0;
                     r_state <= DATA;
                     r_tx    <= r_b_reg[0];
                  end else begin
                     r_s_cnt <= r_s_cnt + SCW'(1);
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (r_s_cnt == S_LAST) begin
                     r_s_cnt <= '0;
                     r_b_reg <= w_b_shift;
                     if (r_n_cnt == N_LAST) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                     end else begin
                        r_n_cnt <= r_n_cnt + NCW'(1);
                        r_tx    <= w_b_shift[0];
                     end
                  end else begin
                     r_s_cnt <= r_s_cnt + SCW'(1);
                  end
               end
            end
            STOP: begin
               if (s_tick) begin
                  if (r_s_cnt == STOP_LAST) begin
                     r_s_cnt <= '0;
                     r_state <= IDLE;
                  end else begin
                     r_s_cnt <= r_s_cnt + SCW'(1);
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   assign fifo.fifo_rd = w_pop;
   assign tx           = r_tx;
   assign tx_busy      = (r_state != IDLE);

endmodule
